// File: rtl/icap_feed_if.sv
// rtl/icap_feed_if.sv - bitstream stream bundle between DMA, icap_feed and the ICAP controller stage
interface icap_feed_if;
  logic [31:0] S_AXIS_TDATA;
  logic        S_AXIS_TVALID;
  logic        S_AXIS_TLAST;
  logic        S_AXIS_TREADY;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TREADY;

  modport slave (
    input  S_AXIS_TDATA, S_AXIS_TVALID, S_AXIS_TLAST, M_AXIS_TREADY,
    output S_AXIS_TREADY, M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST
  );

  modport master (
    output S_AXIS_TDATA, S_AXIS_TVALID, S_AXIS_TLAST, M_AXIS_TREADY,
    input  S_AXIS_TREADY, M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST
  );
endinterface

// File: rtl/icap_feed.sv
// rtl/icap_feed.sv - packet FIFO feeding the ICAP stage; optional sync-word check under ICAP_FEED_SYNC_CHECK_EN
module icap_feed #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_WINDOW = 16
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  icap_feed_if.slave  axis,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] WORD_CNT,
  output logic        SYNC_ERR
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [32:0]       mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [32:0]       head;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              rdy_en;
  logic              pkt_start;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign head  = mem[rd_ptr[ADDR_W-1:0]];

  // Intake closes once the packet's last word is in, and stays shut until DONE has passed.
  assign axis.S_AXIS_TREADY = rdy_en && !full && (state == S_IDLE || state == S_STREAM);
  assign push      = axis.S_AXIS_TVALID && axis.S_AXIS_TREADY;
  assign pop       = !empty && axis.M_AXIS_TREADY;
  assign pkt_start = (state == S_IDLE) && push;

  // Head is masked while empty so the output bus reads zero out of reset.
  assign axis.M_AXIS_TVALID = !empty;
  assign axis.M_AXIS_TDATA  = empty ? 32'h0 : head[31:0];
  assign axis.M_AXIS_TLAST  = !empty && head[32];

  // Storage array: written on every accepted word, no reset needed since pointers gate reads.
  always_ff @(posedge ACLK) begin
    if (push) mem[wr_ptr[ADDR_W-1:0]] <= {axis.S_AXIS_TLAST, axis.S_AXIS_TDATA};
  end

  // Pointer update; reset empties the FIFO and drops any partial packet.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Holds intake off until the first clock edge after reset release.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) rdy_en <= 1'b0;
    else          rdy_en <= 1'b1;
  end

  // Packet sequencer with registered BUSY/DONE.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= S_IDLE;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (push) begin
            state <= axis.S_AXIS_TLAST ? S_DRAIN : S_STREAM;
            BUSY  <= 1'b1;
          end
        end
        S_STREAM: begin
          if (push && axis.S_AXIS_TLAST) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (pop && head[32]) begin
            state <= S_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          DONE  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
        end
      endcase
    end
  end

  // Output word counter: cleared by a new packet, free-running wrap otherwise.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)       WORD_CNT <= 32'h0;
    else if (pkt_start) WORD_CNT <= 32'h0;
    else if (pop)       WORD_CNT <= WORD_CNT + 32'h1;
  end

`ifdef ICAP_FEED_SYNC_CHECK_EN
  localparam logic [31:0] SYNC_WORD = 32'hAA995566;
  localparam int          SW_W      = $clog2(SYNC_WINDOW + 1);

  logic [SW_W-1:0] win_cnt;
  logic            sync_seen;
  logic            in_win;
  logic            hit;

  assign in_win = (win_cnt < SW_W'(SYNC_WINDOW));
  assign hit    = (head[31:0] == SYNC_WORD);

  // Watches the first SYNC_WINDOW output words; flags when the window (or a shorter packet) ends without a sync word.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      win_cnt   <= '0;
      sync_seen <= 1'b0;
      SYNC_ERR  <= 1'b0;
    end else if (pkt_start) begin
      win_cnt   <= '0;
      sync_seen <= 1'b0;
      SYNC_ERR  <= 1'b0;
    end else if (pop && in_win) begin
      win_cnt <= win_cnt + 1'b1;
      if (hit) sync_seen <= 1'b1;
      else if (!sync_seen && (win_cnt == SW_W'(SYNC_WINDOW - 1) || head[32])) SYNC_ERR <= 1'b1;
    end
  end
`else
  logic unused_sync_window;
  assign unused_sync_window = SYNC_WINDOW[0];
  assign SYNC_ERR = 1'b0;
`endif
endmodule

// File: tb/tb_icap_feed.sv
// tb/tb_icap_feed.sv - randomized directed bench for icap_feed against a queue-based packet model
module tb_icap_feed;
  localparam logic [31:0] SYNC = 32'hAA995566;
  localparam int          SW   = 16;
`ifdef ICAP_FEED_SYNC_CHECK_EN
  localparam bit SYNC_EN = 1'b1;
`else
  localparam bit SYNC_EN = 1'b0;
`endif

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b1;
  logic        BUSY;
  logic        DONE;
  logic        SYNC_ERR;
  logic [31:0] WORD_CNT;

  icap_feed_if bus ();

  icap_feed #(.ADDR_W(4), .SYNC_WINDOW(SW)) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .axis    (bus),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .WORD_CNT(WORD_CNT),
    .SYNC_ERR(SYNC_ERR)
  );

  always #5 ACLK = ~ACLK;

  int          n_asrt = 0;
  int          n_fail = 0;
  logic [32:0] tx[$];
  logic [32:0] mq[$];
  logic [31:0] rx[$];
  logic [31:0] gen[$];
  bit          armed, started, closed, done_now, found, serr, gap_en;
  logic [31:0] wcnt;
  int          done_cnt;
  int          mr_mode;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic add_pkt(int len, int sync_pos, bit with_last);
    for (int i = 1; i <= len; i++) begin
      logic [31:0] w;
      w = $urandom;
      if (w == SYNC) w = w ^ 32'h1;
      if (i == sync_pos) w = SYNC;
      tx.push_back({1'(with_last && (i == len)), w});
      gen.push_back(w);
    end
  endtask

  // One clock: drive, check against model, advance model, step past the edge.
  task automatic tick();
    logic        s_hs, m_hs;
    logic [32:0] hd;
    bit          exp_ready;
    if (tx.size() != 0) begin
      bus.S_AXIS_TVALID = !(gap_en && ($urandom_range(0, 3) == 0));
      bus.S_AXIS_TDATA  = tx[0][31:0];
      bus.S_AXIS_TLAST  = tx[0][32];
    end else begin
      bus.S_AXIS_TVALID = 1'b0;
      bus.S_AXIS_TDATA  = $urandom;
      bus.S_AXIS_TLAST  = 1'b0;
    end
    bus.M_AXIS_TREADY = (mr_mode == 1) ? 1'b1 : ((mr_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0);
    #1;
    exp_ready = armed && (mq.size() < 16) && !closed && !done_now;
    chk("s_tready", bus.S_AXIS_TREADY, exp_ready);
    chk("m_tvalid", bus.M_AXIS_TVALID, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("m_tdata", bus.M_AXIS_TDATA, mq[0][31:0]);
      chk("m_tlast", bus.M_AXIS_TLAST, mq[0][32]);
    end
    chk("busy", BUSY, started);
    chk("done", DONE, done_now);
    chk("word_cnt", WORD_CNT, wcnt);
    chk("sync_err", SYNC_ERR, serr);
    if (DONE) done_cnt++;
    s_hs = bus.S_AXIS_TVALID && bus.S_AXIS_TREADY;
    m_hs = bus.M_AXIS_TVALID && bus.M_AXIS_TREADY;
    done_now = 1'b0;
    if (m_hs && mq.size() != 0) begin
      hd = mq.pop_front();
      rx.push_back(bus.M_AXIS_TDATA);
      wcnt = wcnt + 32'h1;
      if (wcnt <= SW && hd[31:0] == SYNC) found = 1'b1;
      if (SYNC_EN && !found && (wcnt == SW || (hd[32] && wcnt < SW))) serr = 1'b1;
      if (hd[32]) begin
        started  = 1'b0;
        closed   = 1'b0;
        done_now = 1'b1;
      end
    end
    if (s_hs && tx.size() != 0) begin
      if (!started) begin
        started = 1'b1;
        wcnt    = 32'h0;
        found   = 1'b0;
        serr    = 1'b0;
      end
      mq.push_back(tx[0]);
      if (tx[0][32]) closed = 1'b1;
      tx.delete(0);
    end
    @(posedge ACLK);
    #1;
    if (ARESETN) armed = 1'b1;
  endtask

  task automatic run_idle(int budget);
    int n;
    n = 0;
    while ((tx.size() != 0 || mq.size() != 0 || started || done_now) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(n < budget), 32'd1);
  endtask

  task automatic cmp_stream(string tag);
    chk({tag, "_len"}, rx.size(), gen.size());
    for (int i = 0; i < rx.size() && i < gen.size(); i++) chk(tag, rx[i], gen[i]);
    rx.delete();
    gen.delete();
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    #1;
    chk("rst_s_tready", bus.S_AXIS_TREADY, 0);
    chk("rst_m_tvalid", bus.M_AXIS_TVALID, 0);
    chk("rst_m_tlast", bus.M_AXIS_TLAST, 0);
    chk("rst_m_tdata", bus.M_AXIS_TDATA, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_word_cnt", WORD_CNT, 0);
    chk("rst_sync_err", SYNC_ERR, 0);
    tx.delete(); mq.delete(); rx.delete(); gen.delete();
    started = 0; closed = 0; done_now = 0; found = 0; serr = 0; armed = 0;
    wcnt = 32'h0;
    @(posedge ACLK);
    @(posedge ACLK);
    #2;
    ARESETN = 1'b1;
    #1;
    chk("rel_s_tready_low", bus.S_AXIS_TREADY, 0);
    @(posedge ACLK);
    #1;
    armed = 1'b1;
  endtask

  initial begin
    bus.S_AXIS_TVALID = 1'b0;
    bus.S_AXIS_TDATA  = 32'h0;
    bus.S_AXIS_TLAST  = 1'b0;
    bus.M_AXIS_TREADY = 1'b0;
    gap_en = 1'b0;
    mr_mode = 0;
    done_cnt = 0;
    do_reset();

    // 8 words 1..8, TLAST on the last, sink always ready
    mr_mode = 1;
    for (int i = 1; i <= 8; i++) begin
      tx.push_back({1'(i == 8), 32'(i)});
      gen.push_back(32'(i));
    end
    done_cnt = 0;
    run_idle(100);
    chk("s1_done_pulses", done_cnt, 1);
    chk("s1_word_cnt", WORD_CNT, 8);
    cmp_stream("s1_data");

    // Sink stalled: 20 offered, 16 fit, then release
    mr_mode = 0;
    add_pkt(20, 0, 1'b1);
    repeat (25) tick();
    chk("s2_accepted", tx.size(), 4);
    chk("s2_full_tready", bus.S_AXIS_TREADY, 0);
    mr_mode = 1;
    run_idle(200);
    chk("s2_word_cnt", WORD_CNT, 20);
    cmp_stream("s2_data");

    // TLAST accepted with 5 queued; next packet waits for the return to IDLE
    mr_mode = 0;
    add_pkt(6, 0, 1'b1);
    repeat (8) tick();
    add_pkt(4, 2, 1'b1);
    repeat (3) tick();
    chk("s3_blocked", tx.size(), 4);
    done_cnt = 0;
    mr_mode = 2;
    run_idle(300);
    chk("s3_done_pulses", done_cnt, 2);
    chk("s3_word_cnt", WORD_CNT, 4);
    cmp_stream("s3_data");

    // Reset with 6 words buffered, then a clean packet
    mr_mode = 0;
    add_pkt(6, 0, 1'b0);
    repeat (8) tick();
    chk("s4_pre_rst_valid", bus.M_AXIS_TVALID, 1);
    bus.M_AXIS_TREADY = 1'b1;
    do_reset();
    mr_mode = 1;
    add_pkt(3, 0, 1'b1);
    run_idle(100);
    cmp_stream("s4_data");

    // Single-word packet
    tx.push_back({1'b1, 32'hFFFFFFFF});
    gen.push_back(32'hFFFFFFFF);
    tick();
    chk("s5_busy_drain", BUSY, 1);
    run_idle(50);
    chk("s5_word_cnt", WORD_CNT, 1);
    chk("s5_sync_err", SYNC_ERR, 32'(SYNC_EN));
    cmp_stream("s5_data");

    // Sync word early, then too late, then a new packet start
    add_pkt(20, 3, 1'b1);
    run_idle(100);
    chk("s6_sync_ok", SYNC_ERR, 0);
    add_pkt(20, 17, 1'b1);
    run_idle(100);
    chk("s6_sync_late", SYNC_ERR, 32'(SYNC_EN));
    add_pkt(2, 1, 1'b1);
    run_idle(50);
    chk("s6_sync_cleared", SYNC_ERR, 0);
    cmp_stream("s6_data");

    // Random packets with random gaps and backpressure
    gap_en = 1'b1;
    mr_mode = 2;
    for (int k = 0; k < 6; k++) begin
      int len;
      len = $urandom_range(1, 24);
      add_pkt(len, $urandom_range(0, len), 1'b1);
      run_idle(1000);
      chk("s7_word_cnt", WORD_CNT, 32'(len));
      cmp_stream("s7_data");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/icap_feed.md
ICAP_FEED -- requirements
Module: icap_feed

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning FIFO depth = 2^ADDR_W words (16).
REQ-002 SHALL have parameter SYNC_WINDOW, default 16, meaning the number of leading output words of a packet searched for the sync word.
REQ-003 SHALL have port ACLK  in  1  sole clock; all logic is rising-edge.
REQ-004 SHALL have port ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port S_AXIS_TDATA  in  32  bitstream word from DMA.
REQ-006 SHALL have port S_AXIS_TVALID  in  1  upstream word valid.
REQ-007 SHALL have port S_AXIS_TLAST  in  1  last word of bitstream packet.
REQ-008 SHALL have port S_AXIS_TREADY  out  1  block accepts word.
REQ-009 SHALL have port M_AXIS_TDATA  out  32  word to ICAP controller stage.
REQ-010 SHALL have port M_AXIS_TVALID  out  1  output word valid.
REQ-011 SHALL have port M_AXIS_TLAST  out  1  output word is packet end.
REQ-012 SHALL have port M_AXIS_TREADY  in  1  downstream accepts word.
REQ-013 SHALL have port BUSY  out  1  high in states STREAM and DRAIN.
REQ-014 SHALL have port DONE  out  1  one-cycle pulse at packet completion.
REQ-015 SHALL have port WORD_CNT  out  32  words sent on M_AXIS in the current or last packet.
REQ-016 SHALL have port SYNC_ERR  out  1  sticky sync-word-missing flag.

Function
REQ-017 SHALL buffer words in a 2^ADDR_W-entry FIFO with 33 bits per entry: data plus TLAST.
REQ-018 S_AXIS_TREADY SHALL be 1 only when the FIFO is not full and the state is IDLE or STREAM.
REQ-019 M_AXIS_TVALID SHALL equal FIFO not-empty; M_AXIS_TDATA and M_AXIS_TLAST SHALL come from the FIFO head.
REQ-020 Latency SHALL be one cycle: a word accepted on S_AXIS at edge N is valid on M_AXIS after edge N.
REQ-021 A simultaneous push and pop SHALL leave the occupancy unchanged; a push while full SHALL be impossible (TREADY=0); read/write pointers SHALL wrap modulo 2^ADDR_W.
REQ-022 Output data SHALL be held stable while M_AXIS_TVALID=1 and M_AXIS_TREADY=0.
REQ-023 FSM states SHALL be IDLE, STREAM, DRAIN, DONE.
REQ-024 The FSM SHALL go IDLE->STREAM on the first S_AXIS handshake; in that same cycle WORD_CNT SHALL clear to 0 and SYNC_ERR SHALL clear.
REQ-025 The FSM SHALL go STREAM->DRAIN on an S_AXIS handshake with TLAST=1; if IDLE sees a TLAST=1 first word, it SHALL go directly to DRAIN.
REQ-026 The FSM SHALL go DRAIN->DONE on the M_AXIS handshake of the TLAST word; DONE->IDLE SHALL be unconditional after one cycle, with DONE=1 only in the DONE state.
REQ-027 WORD_CNT SHALL increment by 1 per M_AXIS handshake, wrap at 2^32, and hold its value in IDLE.

Reset
REQ-028 ARESETN=0 SHALL immediately set: FSM=IDLE, FIFO empty, S_AXIS_TREADY=0, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, BUSY=0, DONE=0, WORD_CNT=0, SYNC_ERR=0.
REQ-029 Reset asserted mid-packet SHALL discard all buffered words; the next accepted word SHALL start a new packet.
REQ-030 S_AXIS_TREADY SHALL rise no earlier than the first edge after ARESETN deasserts.

Configuration
REQ-031 With macro ICAP_FEED_SYNC_CHECK_EN defined, the block SHALL set SYNC_ERR=1 when the first SYNC_WINDOW output words of a packet (or the packet, if shorter) contain no word equal to 32'hAA995566; SYNC_ERR SHALL stay set until the next packet start or reset, and data SHALL still pass unmodified.
REQ-032 Without ICAP_FEED_SYNC_CHECK_EN, SYNC_ERR SHALL be tied to 0 and no sync-check logic SHALL be present.

Verification
REQ-033 Send 8 words 0x1..0x8 with TLAST on 0x8 and M_AXIS_TREADY=1 -> output order 0x1..0x8, TLAST on 0x8 only, one DONE pulse, WORD_CNT=8.
REQ-034 Hold M_AXIS_TREADY=0 and offer 20 words -> 16 accepted, then S_AXIS_TREADY=0; release -> all 20 delivered in order with no duplicates or losses.
REQ-035 Accept TLAST word with 5 words queued -> S_AXIS_TREADY=0 until DONE; the new packet's first word is accepted after the return to IDLE, and WORD_CNT clears.
REQ-036 Assert ARESETN=0 with 6 words buffered -> M_AXIS_TVALID=0 in the same cycle, WORD_CNT=0, and no stale words appear after reset.
REQ-037 With the macro defined: 0xAA995566 as word 3 -> SYNC_ERR=0; word 17 instead -> SYNC_ERR=1 after output word 16; the next packet start clears it.
REQ-038 Single-word packet 0xFFFFFFFF with TLAST -> IDLE->DRAIN->DONE, WORD_CNT=1, and, with the macro defined, SYNC_ERR=1.
